line_tracker_ctrl: RTL and testbench
====================================

LINE_TRACKER_CTRL -- requirements
Module: line_tracker_ctrl

Interface
REQ-001 Parameter N_SENSORS, default 3, meaning number of reflective sensors; SHALL be odd, range 3..7.
REQ-002 Parameter DEBOUNCE, default 4, meaning consecutive stable cycles before a sensor change is accepted; range 1..255.
REQ-003 Parameter LOST_TIMEOUT, default 1000, meaning cycles allowed in RECOVER before stopping; range 1..2^20.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  1 = run the tracking policy; 0 = force stop.
REQ-007 sensor  input  N_SENSORS  asynchronous sensor bits; 1 = line under sensor; bit 0 rightmost, bit N_SENSORS-1 leftmost.
REQ-008 state  output  2  steering action: 00 turn_left, 01 turn_right, 10 go_straight, 11 stop.
REQ-009 lost  output  1  1 while the FSM is in RECOVER or LOST_STOP.

Function
REQ-010 Each sensor bit SHALL pass through a 2-flop synchronizer.
REQ-011 A filtered bit SHALL take the synchronized value only after that value has differed from the filtered value for DEBOUNCE consecutive cycles; any mismatch-free cycle resets that bit's counter.
REQ-012 Position SHALL be the signed sum over filtered-active bits i of (i - C), where C = (N_SENSORS-1)/2, using width clog2(N_SENSORS*N_SENSORS)+1 to prevent overflow.
REQ-013 FSM states SHALL be TRACK, RECOVER, LOST_STOP, HALT.
REQ-014 TRACK: position > 0 -> turn_left; position < 0 -> turn_right; position = 0 with at least one active bit -> go_straight. Last nonzero sign is stored as last_side.
REQ-015 TRACK -> RECOVER when no filtered bit is active. The timeout counter clears on entry.
REQ-016 RECOVER: steer toward last_side (left -> turn_left, right -> turn_right, none recorded -> go_straight). The counter increments each cycle.
REQ-017 RECOVER -> TRACK on the first cycle any filtered bit is active. The TRACK decision of REQ-014 applies in that same update.
REQ-018 RECOVER -> LOST_STOP when the counter reaches LOST_TIMEOUT-1 with no line, so exactly LOST_TIMEOUT cycles are spent in RECOVER. LOST_STOP outputs stop.
REQ-019 LOST_STOP -> TRACK when any filtered bit becomes active.
REQ-020 enable = 0 SHALL move the FSM to HALT from any state (stop, lost = 0) and has priority over all other transitions.
REQ-021 HALT -> TRACK when enable = 1; last_side is cleared.
REQ-022 state and lost SHALL be registered. A clean input edge SHALL reach state in exactly 2 + DEBOUNCE + 1 cycles.
REQ-023 With all bits active (crossing), the block SHALL output go_straight.

Reset
REQ-024 reset SHALL set: FSM to HALT, state = 11, lost = 0, synchronizers 0, filtered bits 0, debounce and timeout counters 0, last_side none.
REQ-025 reset asserted mid-RECOVER SHALL abort recovery with no residual counter value.

Configuration
REQ-026 Macro LINE_TRACKER_DEBOUNCE_EN: when defined, the debounce filter of REQ-011 is present.
REQ-027 When LINE_TRACKER_DEBOUNCE_EN is undefined, filtered bits SHALL equal the synchronizer outputs, the DEBOUNCE parameter is ignored, and latency is 3 cycles.

Structure
REQ-028 Package line_tracker_pkg SHALL hold: action encodings (TURN_LEFT, TURN_RIGHT, GO_STRAIGHT, STOP), the FSM state typedef, and the last_side encoding.
REQ-029 Sub-module sensor_debounce (1 bit, synchronizer plus counter) SHALL be instantiated N_SENSORS times via generate.

Verification (N_SENSORS=3, DEBOUNCE=4, LOST_TIMEOUT=8, macro defined)
REQ-030 reset, then enable=1 and sensor=010 held -> state=10 exactly 7 cycles after the sensor edge; lost=0.
REQ-031 sensor=100 -> state=00; then sensor=001 -> state=01.
REQ-032 glitch sensor 010->000 for 3 cycles then back -> state stays 10 and lost stays 0.
REQ-033 sensor=100 then 000 held -> lost=1 and state=00 for 8 cycles, then state=11; then sensor=010 -> state=10 and lost=0.
REQ-034 during RECOVER (cycle 4 of 8), enable=0 -> next cycle state=11, lost=0; reset asserted mid-RECOVER -> state=11 and the counter restarts from 0.
REQ-035 sensor=111 -> state=10; rebuild without macro -> sensor=010 edge reaches state in 3 cycles.

Source files
------------

// File: rtl/line_tracker_pkg.sv
// Shared encodings for the line tracker: steering actions, FSM states, last-seen side.
package line_tracker_pkg;

  typedef enum logic [1:0] {
    TURN_LEFT   = 2'b00,
    TURN_RIGHT  = 2'b01,
    GO_STRAIGHT = 2'b10,
    STOP        = 2'b11
  } action_t;

  typedef enum logic [1:0] {
    ST_TRACK,
    ST_RECOVER,
    ST_LOST_STOP,
    ST_HALT
  } fsm_state_t;

  typedef enum logic [1:0] {
    SIDE_NONE,
    SIDE_LEFT,
    SIDE_RIGHT
  } side_t;

  function automatic action_t steer_toward(input side_t s);
    case (s)
      SIDE_LEFT:  return TURN_LEFT;
      SIDE_RIGHT: return TURN_RIGHT;
      default:    return GO_STRAIGHT;
    endcase
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One sensor bit: 2-flop synchronizer, then an optional stability filter
// (present only when LINE_TRACKER_DEBOUNCE_EN is defined).
module sensor_debounce #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

`ifdef LINE_TRACKER_DEBOUNCE_EN
  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // Counter tracks consecutive mismatching cycles; any agreeing cycle clears it.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(DEBOUNCE - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign dout = filt_q;
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE != 0);
  assign dout            = sync2_q;
`endif

endmodule

// File: rtl/line_tracker_ctrl.sv
// Line-following steering controller: filtered sensors -> signed position -> FSM.
// Debounce filtering is built in only when LINE_TRACKER_DEBOUNCE_EN is defined.
module line_tracker_ctrl
  import line_tracker_pkg::*;
#(
  parameter int unsigned N_SENSORS    = 3,
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned LOST_TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N_SENSORS-1:0] sensor,
  output logic [1:0]           state,
  output logic                 lost
);

  localparam int unsigned PW     = $clog2(N_SENSORS * N_SENSORS) + 1;
  localparam int          CENTER = int'((N_SENSORS - 1) / 2);
  localparam int unsigned TW     = (LOST_TIMEOUT > 1) ? $clog2(LOST_TIMEOUT) : 1;

  logic [N_SENSORS-1:0] filt;

  for (genvar i = 0; i < N_SENSORS; i++) begin : g_sensor
    sensor_debounce #(
      .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .din  (sensor[i]),
      .dout (filt[i])
    );
  end

  logic signed [PW-1:0] pos;
  logic                 any_active;
  logic                 pos_left;
  logic                 pos_right;

  always_comb begin
    pos = '0;
    for (int unsigned i = 0; i < N_SENSORS; i++) begin
      if (filt[i]) begin
        pos = pos + PW'(int'(i) - CENTER);
      end
    end
  end

  assign any_active = |filt;
  assign pos_right  = pos[PW-1];
  assign pos_left   = !pos[PW-1] && (pos != '0);

  fsm_state_t      fsm_q, fsm_d;
  action_t         action_q, action_d;
  side_t           side_q, side_d;
  logic            lost_q, lost_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q    <= ST_HALT;
      action_q <= STOP;
      side_q   <= SIDE_NONE;
      lost_q   <= 1'b0;
      tmo_q    <= '0;
    end else begin
      fsm_q    <= fsm_d;
      action_q <= action_d;
      side_q   <= side_d;
      lost_q   <= lost_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    if (!enable) begin
      fsm_d = ST_HALT;
    end else begin
      case (fsm_q)
        ST_HALT:      fsm_d = ST_TRACK;
        ST_TRACK:     if (!any_active) fsm_d = ST_RECOVER;
        ST_RECOVER: begin
          if (any_active) begin
            fsm_d = ST_TRACK;
          end else if (tmo_q == TW'(LOST_TIMEOUT - 1)) begin
            fsm_d = ST_LOST_STOP;
          end
        end
        ST_LOST_STOP: if (any_active) fsm_d = ST_TRACK;
        default:      fsm_d = ST_HALT;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered action lines up
  // with the state being entered (e.g. a re-acquired line steers immediately).
  always_comb begin
    action_d = STOP;
    lost_d   = 1'b0;
    side_d   = side_q;
    tmo_d    = '0;
    case (fsm_d)
      ST_TRACK: begin
        if (pos_left) begin
          action_d = TURN_LEFT;
          side_d   = SIDE_LEFT;
        end else if (pos_right) begin
          action_d = TURN_RIGHT;
          side_d   = SIDE_RIGHT;
        end else if (any_active) begin
          action_d = GO_STRAIGHT;
        end
      end
      ST_RECOVER: begin
        lost_d   = 1'b1;
        action_d = steer_toward(side_q);
        if (fsm_q == ST_RECOVER) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_LOST_STOP: lost_d = 1'b1;
      ST_HALT:      side_d = SIDE_NONE;
      default:      ;
    endcase
  end

  assign state = action_q;
  assign lost  = lost_q;

endmodule

// File: tb/tb_line_tracker_ctrl.sv
// Randomised + directed bench for line_tracker_ctrl with a cycle-level reference model and scoreboard.
module tb_line_tracker_ctrl;

  localparam int N   = 3;
  localparam int DEB = 4;
  localparam int LT  = 8;
`ifdef LINE_TRACKER_DEBOUNCE_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif
  localparam int LAT = FILTER_ON ? (3 + DEB) : 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] sensor;
  logic [1:0]   state;
  logic         lost;

  line_tracker_ctrl #(
    .N_SENSORS   (N),
    .DEBOUNCE    (DEB),
    .LOST_TIMEOUT(LT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .sensor(sensor),
    .state (state),
    .lost  (lost)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int st;
    int lo;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: behaviour described directly from the steering rules.
  typedef enum int {M_TRACK, M_RECOVER, M_LOST, M_HALT} mmode_t;
  mmode_t       m_mode;
  int           m_side;   // +1 left, -1 right, 0 none
  int           m_rc;
  logic [N-1:0] m_filt;
  logic [N-1:0] m_hist[$];
  bit           m_valid = 1'b0;

  function automatic int track_act(input int pos, input bit any);
    if (pos > 0) return 0;
    if (pos < 0) return 1;
    if (any)     return 2;
    return 3;
  endfunction

  function automatic int toward(input int side);
    if (side > 0) return 0;
    if (side < 0) return 1;
    return 2;
  endfunction

  task automatic model_step();
    int           pos;
    bit           any;
    int           act;
    exp_t         e;
    logic [N-1:0] h;
    bit           all_mis;
    if (reset) begin
      m_mode = M_HALT;
      m_side = 0;
      m_rc   = 0;
      m_filt = '0;
      m_hist.delete();
      for (int i = 0; i < DEB + 2; i++) m_hist.push_back('0);
      m_valid = 1'b1;
      e.st = 3;
      e.lo = 0;
      exp_q.push_back(e);
      return;
    end
    if (!m_valid) return;
    pos = 0;
    for (int i = 0; i < N; i++) if (m_filt[i]) pos += i - (N - 1) / 2;
    any = (m_filt != '0);
    act = 3;
    if (!enable) begin
      m_mode = M_HALT;
      m_side = 0;
    end else begin
      case (m_mode)
        M_HALT: begin
          m_mode = M_TRACK;
          m_side = 0;
          act    = track_act(pos, any);
        end
        M_TRACK: begin
          if (!any) begin
            m_mode = M_RECOVER;
            m_rc   = 0;
            act    = toward(m_side);
          end else begin
            act = track_act(pos, any);
          end
        end
        M_RECOVER: begin
          if (any) begin
            m_mode = M_TRACK;
            act    = track_act(pos, any);
          end else if (m_rc == LT - 1) begin
            m_mode = M_LOST;
          end else begin
            m_rc++;
            act = toward(m_side);
          end
        end
        default: begin
          if (any) begin
            m_mode = M_TRACK;
            act    = track_act(pos, any);
          end
        end
      endcase
      if (m_mode == M_TRACK && pos > 0) m_side = 1;
      if (m_mode == M_TRACK && pos < 0) m_side = -1;
    end
    // Filter: a bit flips once the synchronized history disagrees with it DEB times in a row.
    for (int b = 0; b < N; b++) begin
      if (FILTER_ON) begin
        all_mis = 1'b1;
        for (int j = 1; j <= DEB; j++) begin
          h = m_hist[j];
          if (h[b] == m_filt[b]) all_mis = 1'b0;
        end
        if (all_mis) m_filt[b] = !m_filt[b];
      end else begin
        h = m_hist[0];
        m_filt[b] = h[b];
      end
    end
    m_hist.push_front(sensor);
    void'(m_hist.pop_back());
    e.st = act;
    e.lo = (m_mode == M_RECOVER || m_mode == M_LOST) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("scoreboard_state", int'(state), e.st);
      check("scoreboard_lost", int'(lost), e.lo);
    end
  end

  task automatic measure_latency(input logic [N-1:0] val, input int target, input string name);
    int n;
    bit seen;
    n      = 0;
    seen   = 1'b0;
    sensor = val;
    while (n < 60 && !seen) begin
      tick();
      n++;
      if (int'(state) == target) seen = 1'b1;
    end
    check(name, seen ? n : -1, LAT);
  endtask

  task automatic measure_recover(input string name, input int steer);
    int  n;
    int  guard;
    bit  done;
    n     = 0;
    guard = 0;
    done  = 1'b0;
    while (guard < 100 && !done) begin
      tick();
      guard++;
      if (lost && int'(state) == steer) n++;
      if (lost && state == 2'b11) done = 1'b1;
    end
    check(name, done ? n : -1, LT);
  endtask

  task automatic wait_lost(input string name);
    int g;
    g = 0;
    while (!lost && g < 50) begin
      tick();
      g++;
    end
    check(name, int'(lost), 1);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    sensor = '0;
    hold(3);
    check("reset_state", int'(state), 3);
    check("reset_lost", int'(lost), 0);

    reset  = 1'b0;
    enable = 1'b1;
    hold(20);
    check("idle_lost_stop", int'(state), 3);

    measure_latency(3'b010, 2, "latency_center");
    check("center_lost", int'(lost), 0);

    sensor = 3'b100; hold(LAT + 3);
    check("left_turn", int'(state), 0);
    sensor = 3'b001; hold(LAT + 3);
    check("right_turn", int'(state), 1);

    sensor = 3'b010; hold(LAT + 3);
    sensor = 3'b000; hold(3);
    sensor = 3'b010; hold(LAT + 3);
    check("after_glitch", int'(state), 2);

    sensor = 3'b100; hold(LAT + 3);
    sensor = 3'b000;
    measure_recover("recover_left_len", 0);
    sensor = 3'b010; hold(LAT + 3);
    check("reacquire_state", int'(state), 2);
    check("reacquire_lost", int'(lost), 0);

    sensor = 3'b100; hold(LAT + 3);
    sensor = 3'b000;
    wait_lost("enter_recover_a");
    hold(3);
    enable = 1'b0;
    tick();
    check("halt_state", int'(state), 3);
    check("halt_lost", int'(lost), 0);

    enable = 1'b1;
    sensor = 3'b100; hold(LAT + 3);
    sensor = 3'b000;
    wait_lost("enter_recover_b");
    hold(3);
    reset = 1'b1;
    tick();
    check("mid_reset_state", int'(state), 3);
    check("mid_reset_lost", int'(lost), 0);
    reset = 1'b0;
    measure_recover("recover_after_reset_len", 2);

    sensor = 3'b111; hold(LAT + 3);
    check("crossing", int'(state), 2);

    for (int k = 0; k < 250; k++) begin
      sensor = N'($urandom_range(0, 7));
      enable = ($urandom_range(0, 19) != 0);
      reset  = ($urandom_range(0, 49) == 0);
      tick();
      reset = 1'b0;
      hold(int'($urandom_range(0, 10)));
    end

    enable = 1'b1;
    hold(LAT + 3);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
